smg_scan_scheduler: RTL and testbench

Time-multiplexed scan scheduler for the multi-digit seven-segment display.
- Sequences digit slots with a fixed dwell time per slot.
- Inserts a blanking interval at the start of every slot to suppress ghosting.
- Drives active-low one-hot digit selects alongside the 4-bit digit code.
- Accepts new display values only at frame boundaries through a req/ack handshake, so a frame never shows mixed old and new digits. The 4-bit code feeds the segment decoder downstream.

---
 rtl/smg_pkg.sv | 29 ++
 rtl/smg_tick_counter.sv | 37 +++
 rtl/smg_scan_scheduler.sv | 79 +++++++
 tb/tb_smg_scan_scheduler.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/smg_pkg.sv
// rtl/smg_pkg.sv - shared widths, select constants and helper functions for the seven-segment scan scheduler
package smg_pkg;
    localparam int CODE_W     = 4;
    localparam int MAX_DIGITS = 8;

    typedef logic [CODE_W-1:0] code_t;

    localparam logic [MAX_DIGITS-1:0] DIGIT_OFF = '1;

    function automatic logic [MAX_DIGITS-1:0] onehot_low(input logic [2:0] idx);
        return ~(8'b1 << idx);
    endfunction

    // Marks the run of zero digits starting at the top; digit 0 always stays visible.
    function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [4*MAX_DIGITS-1:0] val,
                                                      input int digits);
        logic [MAX_DIGITS-1:0] m;
        logic                  lead;
        m    = '0;
        lead = 1'b1;
        for (int k = MAX_DIGITS - 1; k >= 1; k--) begin
            if (k < digits) begin
                if (lead && val[4*k +: 4] == 4'h0) m[k] = 1'b1;
                else                               lead = 1'b0;
            end
        end
        return m;
    endfunction
endpackage

// File: rtl/smg_tick_counter.sv
// rtl/smg_tick_counter.sv - dwell counter and slot index with blank and frame-boundary flags
module smg_tick_counter #(
    parameter int DIGITS = 3,
    parameter int DWELL  = 49999,
    parameter int BLANK  = 999,
    parameter int IW     = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
    input  logic          CLK,
    input  logic          RSTn,
    output logic [IW-1:0] idx,
    output logic          in_view,
    output logic          boundary
);
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST_C     = CW'(DWELL);
    localparam logic [CW-1:0] FIRST_VIEW = CW'(BLANK);
    localparam logic [IW-1:0] LAST_IDX   = IW'(DIGITS - 1);

    logic [CW-1:0] cnt;
    logic          slot_end;

    assign slot_end = (cnt == LAST_C);
    assign boundary = slot_end && (idx == LAST_IDX);
    assign in_view  = (cnt >= FIRST_VIEW);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt <= '0;
            idx <= '0;
        end else if (slot_end) begin
            cnt <= '0;
            idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/smg_scan_scheduler.sv
// rtl/smg_scan_scheduler.sv - frame-synchronous digit scan with req/ack value loading
// Optional leading-zero suppression: SMG_LZ_SUPPRESS_EN.
module smg_scan_scheduler
    import smg_pkg::*;
#(
    parameter int DIGITS = 3,
    parameter int DWELL  = 49999,
    parameter int BLANK  = 999
) (
    input  logic                     CLK,
    input  logic                     RSTn,
    input  logic                     Load_Req,
    input  logic [4*DIGITS-1:0]      Number_Sig,
    output logic                     Load_Ack,
    output logic [CODE_W-1:0]        Number_Data,
    output logic [DIGITS-1:0]        Digit_Sel,
    output logic                     Frame_Done
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [IW-1:0]          idx;
    logic                   in_view;
    logic                   boundary;
    logic                   capture;
    logic                   show;
    logic [4*DIGITS-1:0]    shadow;
    logic [MAX_DIGITS-1:0]  sel_low;

    smg_tick_counter #(
        .DIGITS (DIGITS),
        .DWELL  (DWELL),
        .BLANK  (BLANK),
        .IW     (IW)
    ) u_tick (
        .CLK      (CLK),
        .RSTn     (RSTn),
        .idx      (idx),
        .in_view  (in_view),
        .boundary (boundary)
    );

    assign capture = boundary && Load_Req;
    assign sel_low = onehot_low(3'(idx));

`ifdef SMG_LZ_SUPPRESS_EN
    logic [DIGITS-1:0]     mask;
    logic [MAX_DIGITS-1:0] mask_next;

    always_comb begin
        mask_next = lz_mask((4*MAX_DIGITS)'(Number_Sig), DIGITS);
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)        mask <= '0;
        else if (capture) mask <= mask_next[DIGITS-1:0];
    end

    assign show = in_view && !mask[idx];
`else
    assign show = in_view;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            shadow      <= '0;
            Load_Ack    <= 1'b0;
            Frame_Done  <= 1'b0;
            Number_Data <= '0;
            Digit_Sel   <= DIGIT_OFF[DIGITS-1:0];
        end else begin
            if (capture) shadow <= Number_Sig;
            Load_Ack    <= capture;
            Frame_Done  <= boundary;
            // Old shadow is used here on the boundary cycle, so the new values start cleanly at slot 0.
            Number_Data <= shadow[{idx, 2'b00} +: CODE_W];
            Digit_Sel   <= show ? sel_low[DIGITS-1:0] : DIGIT_OFF[DIGITS-1:0];
        end
    end
endmodule

// File: tb/tb_smg_scan_scheduler.sv
// tb/tb_smg_scan_scheduler.sv - directed self-checking bench for smg_scan_scheduler (DIGITS=3, DWELL=9, BLANK=2)
module tb_smg_scan_scheduler;
    logic        CLK;
    logic        RSTn;
    logic        Load_Req;
    logic [11:0] Number_Sig;
    logic        Load_Ack;
    logic [3:0]  Number_Data;
    logic [2:0]  Digit_Sel;
    logic        Frame_Done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    smg_scan_scheduler #(
        .DIGITS (3),
        .DWELL  (9),
        .BLANK  (2)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .Load_Req    (Load_Req),
        .Number_Sig  (Number_Sig),
        .Load_Ack    (Load_Ack),
        .Number_Data (Number_Data),
        .Digit_Sel   (Digit_Sel),
        .Frame_Done  (Frame_Done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge CLK);
        @(negedge CLK);
        cyc++;
    endtask

    task automatic wait_to(input int k);
        while (cyc < k) next_cycle();
    endtask

    initial begin
        RSTn       = 1'b0;
        Load_Req   = 1'b0;
        Number_Sig = '0;
        repeat (3) @(negedge CLK);
        check("rst_sel",   32'(Digit_Sel),   7);
        check("rst_data",  32'(Number_Data), 0);
        check("rst_ack",   32'(Load_Ack),    0);
        check("rst_frame", 32'(Frame_Done),  0);

        RSTn = 1'b1;
        cyc  = 0;
        wait_to(2);  check("sel_c2",  32'(Digit_Sel), 7);
        wait_to(3);  check("sel_c3",  32'(Digit_Sel), 6);
        wait_to(5);
        Load_Req   = 1'b1;
        Number_Sig = 12'h321;
        wait_to(10); check("sel_c10", 32'(Digit_Sel), 6);
        wait_to(11); check("sel_c11", 32'(Digit_Sel), 7);
        wait_to(12); check("sel_c12", 32'(Digit_Sel), 7);
        wait_to(13); check("sel_c13", 32'(Digit_Sel), 5);
        wait_to(23); check("sel_c23", 32'(Digit_Sel), 3);
        wait_to(29);
        check("ack_c29",   32'(Load_Ack),   0);
        check("frame_c29", 32'(Frame_Done), 0);
        wait_to(30);
        check("ack_c30",   32'(Load_Ack),    1);
        check("frame_c30", 32'(Frame_Done),  1);
        check("data_c30",  32'(Number_Data), 0);
        Load_Req = 1'b0;
        wait_to(31);
        check("ack_c31",   32'(Load_Ack),    0);
        check("frame_c31", 32'(Frame_Done),  0);
        check("data_c31",  32'(Number_Data), 1);
        wait_to(40); check("data_c40", 32'(Number_Data), 1);
        wait_to(41); check("data_c41", 32'(Number_Data), 2);
        wait_to(51); check("data_c51", 32'(Number_Data), 3);
        wait_to(60); check("frame_c60", 32'(Frame_Done), 1);

        // Inputs churn with no request, plus one request withdrawn before the boundary.
        while (cyc < 148) begin
            next_cycle();
            Load_Req   = (cyc >= 100 && cyc < 105);
            Number_Sig = Load_Req ? 12'h999 : 12'(cyc * 37);
            case (cyc)
                65:  check("hold_c65",  32'(Number_Data), 1);
                75:  check("hold_c75",  32'(Number_Data), 2);
                85:  check("hold_c85",  32'(Number_Data), 3);
                95:  check("hold_c95",  32'(Number_Data), 1);
                120: begin
                    check("wd_ack_c120",   32'(Load_Ack),   0);
                    check("wd_frame_c120", 32'(Frame_Done), 1);
                end
                121: check("wd_data_c121", 32'(Number_Data), 1);
                135: check("wd_data_c135", 32'(Number_Data), 2);
                default: ;
            endcase
        end

        wait_to(149);
        Load_Req   = 1'b1;
        Number_Sig = 12'h7a4;
        check("bnd_ack_c149", 32'(Load_Ack), 0);
        wait_to(150);
        check("bnd_ack_c150", 32'(Load_Ack), 1);
        Load_Req = 1'b0;
        wait_to(151); check("bnd_data_c151", 32'(Number_Data), 4);
        wait_to(161); check("bnd_data_c161", 32'(Number_Data), 'ha);
        wait_to(171); check("bnd_data_c171", 32'(Number_Data), 7);
        wait_to(177);
        check("pre_rst_sel", 32'(Digit_Sel), 3);

        #1 RSTn = 1'b0;
        #1;
        check("async_sel",  32'(Digit_Sel),   7);
        check("async_data", 32'(Number_Data), 0);
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        cyc  = 0;
        wait_to(2);  check("r2_sel_c2",  32'(Digit_Sel),   7);
        wait_to(3);  check("r2_sel_c3",  32'(Digit_Sel),   6);
        wait_to(5);  check("r2_data_c5", 32'(Number_Data), 0);
        wait_to(13); check("r2_sel_c13", 32'(Digit_Sel),   5);
        wait_to(15); check("r2_data_c15", 32'(Number_Data), 0);

        wait_to(29);
        Load_Req   = 1'b1;
        Number_Sig = 12'h005;
        wait_to(30);
        check("lz_ack_c30", 32'(Load_Ack), 1);
        Load_Req = 1'b0;
        wait_to(33);
        check("lz5_sel_c33",  32'(Digit_Sel),   6);
        check("lz5_data_c33", 32'(Number_Data), 5);
        wait_to(43);
        check("lz5_data_c43", 32'(Number_Data), 0);
`ifdef SMG_LZ_SUPPRESS_EN
        check("lz5_sel_c43", 32'(Digit_Sel), 7);
        wait_to(53); check("lz5_sel_c53", 32'(Digit_Sel), 7);
`else
        check("lz5_sel_c43", 32'(Digit_Sel), 5);
        wait_to(53); check("lz5_sel_c53", 32'(Digit_Sel), 3);
`endif
        wait_to(59);
        Load_Req   = 1'b1;
        Number_Sig = 12'h000;
        wait_to(60);
        check("lz0_ack_c60", 32'(Load_Ack), 1);
        Load_Req = 1'b0;
        wait_to(63);
        check("lz0_sel_c63",  32'(Digit_Sel),   6);
        check("lz0_data_c63", 32'(Number_Data), 0);
`ifdef SMG_LZ_SUPPRESS_EN
        wait_to(73); check("lz0_sel_c73", 32'(Digit_Sel), 7);
        wait_to(83); check("lz0_sel_c83", 32'(Digit_Sel), 7);
`else
        wait_to(73); check("lz0_sel_c73", 32'(Digit_Sel), 5);
        wait_to(83); check("lz0_sel_c83", 32'(Digit_Sel), 3);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
